uart_frame_parse: RTL and testbench
===================================

Name: uart_frame_parse

Overview:
- Consumes the byte stream produced by the UART receiver (`uart_rx_done` / `uart_rx_data`).
- Parses framed packets, checks a checksum, and packs the payload into 32-bit little-endian words.
- Pushes those words into the downstream write FIFO that feeds the DDR write path.
- Reports frame completion or frame error to the control logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz (documentation/consistency only).
- TIMEOUT_CYC, 50_000, inter-byte timeout in clk cycles while a frame is open; must be in 2..2^24-1.
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- uart_rx_done  input  1  one-cycle pulse; byte valid on uart_rx_data
- uart_rx_data  input  8  received byte
- wr_en  output  1  one-cycle pulse; wr_data valid
- wr_data  output  32  packed payload word, byte k of payload in bits [8*(k%4)+7 : 8*(k%4)]
- frame_done  output  1  one-cycle pulse; frame received with correct checksum
- frame_err  output  1  one-cycle pulse; frame aborted (bad LEN, bad checksum, timeout)
- frame_len  output  8  LEN of the last frame_done frame; held until the next frame_done
- busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; byte index, packing register, checksum and timeout counter all 0.
- Frame format: HDR0, HDR1, LEN (1..255), LEN payload bytes, CHK.
- Checksum: CHK = (LEN + sum of payload bytes) mod 256, using an 8-bit wrapping accumulator.
- States and transitions, each evaluated only on cycles where uart_rx_done = 1:
  - IDLE: byte == HDR0 -> HDR; any other byte -> stay in IDLE.
  - HDR: byte == HDR1 -> LEN. Byte == HDR0 -> stay in HDR (resync). Any other byte -> IDLE, no error pulse.
  - LEN: byte == 0 -> frame_err, IDLE. Otherwise store LEN, set checksum = byte, index = 0 -> DATA.
  - DATA: add byte to checksum and write it into lane index%4.
    - If index%4 == 3, or index == LEN-1: wr_en pulses next cycle with the packed word.
    - Unwritten upper lanes of a short final word are 8'h00.
    - Packing register is cleared after each emit.
    - index == LEN-1 -> CHK.
  - CHK: byte == checksum -> frame_done pulse and frame_len <= LEN. Mismatch -> frame_err. Either way -> IDLE.
- Latency: wr_en, frame_done and frame_err are registered, asserting 1 clk after the uart_rx_done that caused them. They never assert in the same cycle as each other.
- Words are emitted before the checksum is known. On frame_err, words already written are not recalled; the consumer discards data using frame_err.
- Timeout:
  - The counter runs in every state except IDLE and clears on every uart_rx_done.
  - Reaching TIMEOUT_CYC-1 triggers: frame_err pulse (HDR state excepted: silent return), -> IDLE, partial packing word discarded (no wr_en).
  - uart_rx_done in the same cycle as timeout expiry: the byte wins, the counter clears and no timeout occurs.
- Back-to-back frames: a HDR0 byte arriving immediately after CHK is accepted (IDLE processes it in its first cycle).
- Reset mid-frame: immediate return to IDLE, all pulses deasserted, no partial word emitted.
- No backpressure: the downstream FIFO must absorb one word per 4 bytes. UART byte rate guarantees at least BAUD period * 10 cycles between wr_en pulses.

Decomposition:
- Shared package uart_pkg:
  - HDR0/HDR1 default constants.
  - State encoding localparams: IDLE=0, HDR=1, LEN=2, DATA=3, CHK=4 (3-bit).
  - Timeout counter width (24).
- One natural sub-module: uart_word_pack (byte lane write, zero-pad flush, emit pulse, clear). The FSM, checksum and timeout stay in the top.

Test Plan:
- Good frame 55 AA 05 11 22 33 44 55 04 -> wr_en with 32'h44332211, then with 32'h00000055; frame_done once; frame_len = 5; frame_err never.
- Same frame with CHK = 8'h05 -> both words still written; frame_err pulse 1 clk after last byte; frame_done never; frame_len unchanged.
- LEN = 0 (55 AA 00) -> frame_err; busy drops; a following good frame parses normally.
- Resync stream 55 55 AA 01 7E 7F -> wr_en with 32'h0000007E; frame_done; frame_len = 1.
- Stall after 55 AA 03 10 for TIMEOUT_CYC cycles -> frame_err exactly once, no wr_en, busy = 0. Repeat with a byte landing on the expiry cycle -> no error.
- rst_n asserted mid-DATA after 2 payload bytes -> all outputs 0 immediately; no wr_en after release; next good frame passes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART frame parser.
// Imported by the parser top and its word packer.
package uart_pkg;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;
  localparam int         TMO_W    = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_word_pack.sv
// Packs payload bytes into little-endian 32-bit words.
// A short final word is flushed zero-padded.
module uart_word_pack
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [1:0]  lane,
  input  logic [7:0]  data,
  input  logic        emit,
  input  logic        clr,
  output logic        wr_en,
  output logic [31:0] wr_data
);

  logic [31:0] word_q;
  logic [31:0] word_nx;

  always_comb begin
    word_nx = word_q;
    unique case (lane)
      2'd0: word_nx[7:0]   = data;
      2'd1: word_nx[15:8]  = data;
      2'd2: word_nx[23:16] = data;
      2'd3: word_nx[31:24] = data;
      default: word_nx = word_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (clr) begin
        word_q <= '0;
      end else if (wr) begin
        if (emit) begin
          wr_en   <= 1'b1;
          wr_data <= word_nx;
          word_q  <= '0;
        end else begin
          word_q <= word_nx;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_parse.sv
// Frame parser: header sync, length, checksum and inter-byte timeout.
// Payload goes to uart_word_pack; status pulses are registered.
module uart_frame_parse
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         TIMEOUT_CYC = 50_000,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_done,
  input  logic [7:0]  uart_rx_data,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  frame_len,
  output logic        busy
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 24'hFF_FFFF || CLK_FREQ <= 0)
  begin : g_bad_param
    $error("uart_frame_parse: bad TIMEOUT_CYC or CLK_FREQ");
  end

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [TMO_W-1:0] tcnt_q;
  logic             done_d, err_d;
  logic             pk_wr, pk_emit, pk_clr;
  logic             tmo;
  logic             last_b;

  // A byte on the expiry cycle wins over the timeout.
  assign tmo = (state_q != ST_IDLE) && !uart_rx_done
             && (tcnt_q == TMO_LAST);
  assign last_b = (idx_q == len_q - 8'd1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pk_wr   = 1'b0;
    pk_emit = 1'b0;
    pk_clr  = 1'b0;
    if (tmo) begin
      state_d = ST_IDLE;
      err_d   = (state_q != ST_HDR);
      pk_clr  = 1'b1;
    end else if (uart_rx_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (uart_rx_data == HDR0) state_d = ST_HDR;
        end
        ST_HDR: begin
          if (uart_rx_data == HDR1)
            state_d = ST_LEN;
          else if (uart_rx_data != HDR0)
            state_d = ST_IDLE;
        end
        ST_LEN: begin
          if (uart_rx_data == 8'd0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            len_d   = uart_rx_data;
            chk_d   = uart_rx_data;
            idx_d   = 8'd0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          chk_d   = chk_q + uart_rx_data;
          pk_wr   = 1'b1;
          pk_emit = (idx_q[1:0] == 2'd3) || last_b;
          if (last_b) state_d = ST_CHK;
          else        idx_d   = idx_q + 8'd1;
        end
        ST_CHK: begin
          done_d  = (uart_rx_data == chk_q);
          err_d   = (uart_rx_data != chk_q);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_len  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      frame_done <= done_d;
      frame_err  <= err_d;
      if (done_d) frame_len <= len_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt_q <= '0;
    else if (state_q == ST_IDLE || uart_rx_done || tmo)
      tcnt_q <= '0;
    else
      tcnt_q <= tcnt_q + 1'b1;
  end

  assign busy = (state_q != ST_IDLE);

  uart_word_pack u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (pk_wr),
    .lane    (idx_q[1:0]),
    .data    (uart_rx_data),
    .emit    (pk_emit),
    .clr     (pk_clr),
    .wr_en   (wr_en),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_uart_frame_parse.sv
// Directed bench for uart_frame_parse with a short timeout.
// Inputs change on negedge; outputs are read on negedge.
module tb_uart_frame_parse;

  localparam int TMO = 40;

  logic        clk;
  logic        rst_n;
  logic        uart_rx_done;
  logic [7:0]  uart_rx_data;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  frame_len;
  logic        busy;

  int checks;
  int errors;
  int n_done;
  int n_err;
  logic [31:0] wq[$];
  logic [7:0]  seq[$];

  uart_frame_parse #(
    .CLK_FREQ    (50_000_000),
    .TIMEOUT_CYC (TMO),
    .HDR0        (8'h55),
    .HDR1        (8'hAA)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx_done (uart_rx_done),
    .uart_rx_data (uart_rx_data),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_len    (frame_len),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wq.push_back(wr_data);
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (int'(wr_en) + int'(frame_done) + int'(frame_err) > 1) begin
      checks++;
      errors++;
      $display("FAIL pulse_overlap: wr_en=%b done=%b err=%b, required at most one",
               wr_en, frame_done, frame_err);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    @(negedge clk);
    uart_rx_done = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_seq(input int g);
    for (int i = 0; i < seq.size(); i++) begin
      send_byte(seq[i]);
      if (i != seq.size() - 1) gap(g);
    end
  endtask

  task automatic clr_mon();
    wq.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  task automatic chk_word(input string nm, input int k,
                          input logic [31:0] exp);
    checks++;
    if (wq.size() <= k) begin
      errors++;
      $display("FAIL %s: word %0d missing, required %h", nm, k, exp);
    end else if (wq[k] !== exp) begin
      errors++;
      $display("FAIL %s: word %0d got %h, required %h", nm, k, wq[k], exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'h00;
    gap(3);
    checks++;
    if ({wr_en, wr_data, frame_done, frame_err, frame_len, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b %h %b %b %h %b, required all 0",
               wr_en, wr_data, frame_done, frame_err, frame_len, busy);
    end
    rst_n = 1'b1;
    gap(2);
  endtask

  task automatic test_good_frame();
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h04};
    send_seq(2);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_done_latency: done=%b busy=%b, required 1 0",
               frame_done, busy);
    end
    gap(3);
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL good_word_count: got %0d, required 2", wq.size());
    end
    chk_word("good_w0", 0, 32'h44332211);
    chk_word("good_w1", 1, 32'h00000055);
    checks++;
    if (n_done != 1 || n_err != 0 || frame_len !== 8'd5) begin
      errors++;
      $display("FAIL good_status: done=%0d err=%0d len=%0d, required 1 0 5",
               n_done, n_err, frame_len);
    end
  endtask

  task automatic test_bad_chk();
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h05};
    send_seq(2);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL badchk_err_latency: got %b, required 1", frame_err);
    end
    gap(3);
    chk_word("badchk_w0", 0, 32'h44332211);
    chk_word("badchk_w1", 1, 32'h00000055);
    checks++;
    if (n_done != 0 || n_err != 1 || frame_len !== 8'd5) begin
      errors++;
      $display("FAIL badchk_status: done=%0d err=%0d len=%0d, required 0 1 5",
               n_done, n_err, frame_len);
    end
  endtask

  task automatic test_len_zero();
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h00};
    send_seq(2);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_err: err=%b busy=%b, required 1 0", frame_err, busy);
    end
    gap(2);
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h02, 8'hF0, 8'h0F, 8'h01};
    send_seq(1);
    gap(2);
    chk_word("len0_next_w0", 0, 32'h00000FF0);
    checks++;
    if (n_done != 1 || n_err != 0 || frame_len !== 8'd2) begin
      errors++;
      $display("FAIL len0_next: done=%0d err=%0d len=%0d, required 1 0 2",
               n_done, n_err, frame_len);
    end
  endtask

  task automatic test_resync();
    clr_mon();
    seq = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
    send_seq(2);
    gap(2);
    chk_word("resync_w0", 0, 32'h0000007E);
    checks++;
    if (n_done != 1 || n_err != 0 || frame_len !== 8'd1 || wq.size() != 1) begin
      errors++;
      $display("FAIL resync_status: done=%0d err=%0d len=%0d words=%0d, required 1 0 1 1",
               n_done, n_err, frame_len, wq.size());
    end
  endtask

  task automatic test_timeout();
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h03, 8'h10};
    send_seq(2);
    gap(TMO - 1);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: err=%b busy=%b, required 0 1", frame_err, busy);
    end
    gap(1);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: err=%b busy=%b, required 1 0", frame_err, busy);
    end
    gap(TMO + 10);
    checks++;
    if (n_err != 1 || wq.size() != 0 || n_done != 0) begin
      errors++;
      $display("FAIL tmo_once: err=%0d words=%0d done=%0d, required 1 0 0",
               n_err, wq.size(), n_done);
    end
  endtask

  task automatic test_timeout_edge();
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h03, 8'h10};
    send_seq(2);
    gap(TMO - 1);
    send_byte(8'h20);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_edge_byte_wins: err=%b busy=%b, required 0 1",
               frame_err, busy);
    end
    gap(2);
    seq = '{8'h30, 8'h63};
    send_seq(2);
    gap(2);
    chk_word("tmo_edge_w0", 0, 32'h00302010);
    checks++;
    if (n_err != 0 || n_done != 1 || frame_len !== 8'd3) begin
      errors++;
      $display("FAIL tmo_edge_status: err=%0d done=%0d len=%0d, required 0 1 3",
               n_err, n_done, frame_len);
    end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h05,
            8'h55, 8'hAA, 8'h01, 8'h09, 8'h0A};
    send_seq(0);
    gap(2);
    chk_word("b2b_w0", 0, 32'h00000201);
    chk_word("b2b_w1", 1, 32'h00000009);
    checks++;
    if (n_done != 2 || n_err != 0 || frame_len !== 8'd1) begin
      errors++;
      $display("FAIL b2b_status: done=%0d err=%0d len=%0d, required 2 0 1",
               n_done, n_err, frame_len);
    end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    seq = '{8'h55, 8'hAA, 8'h04, 8'hA1, 8'hA2};
    send_seq(2);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_data, frame_done, frame_err, frame_len, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b %h %b %b %h %b, required all 0",
               wr_en, wr_data, frame_done, frame_err, frame_len, busy);
    end
    gap(2);
    rst_n = 1'b1;
    gap(TMO + 5);
    checks++;
    if (wq.size() != 0 || n_err != 0) begin
      errors++;
      $display("FAIL midreset_quiet: words=%0d err=%0d, required 0 0",
               wq.size(), n_err);
    end
    seq = '{8'h55, 8'hAA, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h8E};
    send_seq(1);
    gap(2);
    chk_word("midreset_next_w0", 0, 32'hA4A3A2A1);
    checks++;
    if (n_done != 1 || n_err != 0 || frame_len !== 8'd4 || wq.size() != 1) begin
      errors++;
      $display("FAIL midreset_next: done=%0d err=%0d len=%0d words=%0d, required 1 0 4 1",
               n_done, n_err, frame_len, wq.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_zero();
    test_resync();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
